// File: rtl/wb_arbiter_n_pkg.sv
// Shared types and helpers for the N-master Wishbone pipelined arbiter.
package wb_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Widest one-hot vector the index helper accepts.
    localparam int ARB_MAX_NM = 32;

    // Index of the set bit in a one-hot vector (0 when no bit is set).
    function automatic int onehot_to_idx(input logic [ARB_MAX_NM-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < ARB_MAX_NM; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_arbiter_n_rr_pick.sv
// Combinational winner picker: fixed priority (lowest index) or round-robin
// (first requester after the pointer, wrapping).
module arb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NM = 2,
    parameter int IW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] ptr,
    input  arb_mode_t     mode,
    output logic [NM-1:0] win
);

    logic [IW-1:0] idx;

    // Scan from the lowest-priority slot upward so the last hit is the winner.
    always_comb begin
        win = '0;
        idx = '0;
        if (mode == ARB_FIXED) begin
            for (int i = NM - 1; i >= 0; i--) begin
                if (req[i]) begin
                    win    = '0;
                    win[i] = 1'b1;
                end
            end
        end else begin
            for (int i = NM; i >= 1; i--) begin
                idx = IW'((int'(ptr) + i) % NM);
                if (req[idx]) begin
                    win      = '0;
                    win[idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave Wishbone pipelined arbiter with fixed or round-robin
// arbitration, outstanding-strobe tracking and grant hold until acks drain.
module wb_arbiter_n
    import wb_arb_pkg::*;
#(
    parameter int NM      = 2,
    parameter int AW      = 15,
    parameter int DW      = 32,
    parameter int MODE    = 0,
    parameter int MAX_OUT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NM-1:0]        cyc_i,
    input  logic [NM-1:0]        stb_i,
    input  logic [NM-1:0]        we_i,
    input  logic [NM*(DW/8)-1:0] sel_i,
    input  logic [NM*AW-1:0]     adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    output logic [NM*DW-1:0]     m_dat_o,
    output logic [NM-1:0]        stall_o,
    output logic [NM-1:0]        ack_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [DW/8-1:0]      sel_o,
    output logic [AW-1:0]        adr_o,
    output logic [DW-1:0]        s_dat_o,
    input  logic [DW-1:0]        s_dat_i,
    input  logic                 ack_i,
    input  logic                 stall_i,
    output logic [NM-1:0]        grant_o,
    output logic                 err_o
);

    localparam int        SW       = DW / 8;
    localparam int        IW       = (NM > 1) ? $clog2(NM) : 1;
    localparam arb_mode_t ARB_MODE = (MODE == 1) ? ARB_RR : ARB_FIXED;
    localparam logic [3:0] OUT_MAX = 4'(MAX_OUT);

    arb_state_t    state, state_nxt;
    logic [NM-1:0] grant, grant_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [3:0]    out_cnt, out_nxt;
    logic          err, err_nxt;

    logic          own_cyc, own_stb, own_we;
    logic [SW-1:0] own_sel;
    logic [AW-1:0] own_adr;
    logic [DW-1:0] own_dat;

    logic          busy, full, release_own, ack_fwd, accept;
    logic [NM-1:0] pick_req, win;

    // Route the current owner's bus signals toward the slave.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_sel = '0;
        own_adr = '0;
        own_dat = '0;
        for (int k = 0; k < NM; k++) begin
            if (grant[k]) begin
                own_cyc = cyc_i[k];
                own_stb = stb_i[k];
                own_we  = we_i[k];
                own_sel = sel_i[k*SW +: SW];
                own_adr = adr_i[k*AW +: AW];
                own_dat = m_dat_i[k*DW +: DW];
            end
        end
    end

    // The departing owner is never eligible on the edge that releases it.
    assign pick_req = (state == ARB_BUSY) ? (cyc_i & ~grant) : cyc_i;

    arb_rr_pick #(
        .NM (NM),
        .IW (IW)
    ) u_pick (
        .req  (pick_req),
        .ptr  (ptr),
        .mode (ARB_MODE),
        .win  (win)
    );

    // Slave-side and master-side handshakes for the granted master.
    always_comb begin
        busy        = (state == ARB_BUSY);
        full        = (out_cnt == OUT_MAX);
        release_own = busy & ~own_cyc;
        cyc_o       = busy & own_cyc;
        stb_o       = cyc_o & own_stb & ~full;
        we_o        = own_we;
        sel_o       = own_sel;
        adr_o       = own_adr;
        s_dat_o     = own_dat;
        accept      = stb_o & ~stall_i;
        ack_fwd     = busy & ack_i & (out_cnt != 4'd0);
        ack_o       = ack_fwd ? grant : '0;
        for (int k = 0; k < NM; k++) begin
            stall_o[k] = (busy & grant[k]) ? (stall_i | full) : cyc_i[k];
        end
    end

    assign m_dat_o = {NM{s_dat_i}};
    assign grant_o = grant;
    assign err_o   = err;

    // Next-state: arbitration, release/abort hand-over and outstanding count.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        out_nxt   = out_cnt;
        err_nxt   = err | (ack_i & (out_cnt == 4'd0));
        case (state)
            ARB_IDLE: begin
                out_nxt = 4'd0;
                if (|win) begin
                    state_nxt = ARB_BUSY;
                    grant_nxt = win;
                    ptr_nxt   = IW'(onehot_to_idx(ARB_MAX_NM'(win)));
                end
            end
            ARB_BUSY: begin
                if (release_own) begin
                    // Abort or normal release: late acks are treated as stray.
                    out_nxt = 4'd0;
                    if (|win) begin
                        grant_nxt = win;
                        ptr_nxt   = IW'(onehot_to_idx(ARB_MAX_NM'(win)));
                    end else begin
                        state_nxt = ARB_IDLE;
                        grant_nxt = '0;
                    end
                end else if (accept && !ack_fwd) begin
                    out_nxt = out_cnt + 4'd1;
                end else if (ack_fwd && !accept) begin
                    out_nxt = out_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
                out_nxt   = 4'd0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= ARB_IDLE;
            grant   <= '0;
            ptr     <= IW'(NM - 1);
            out_cnt <= 4'd0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            ptr     <= ptr_nxt;
            out_cnt <= out_nxt;
            err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed bench: a 2-master fixed-priority arbiter and a 4-master
// round-robin arbiter share clock and reset.
module tb_wb_arbiter_n;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 2-master fixed-priority instance
    logic [1:0]  f_cyc = '0, f_stb = '0, f_we = '0;
    logic [7:0]  f_sel = '0;
    logic [29:0] f_adr = '0;
    logic [63:0] f_mdat = '0;
    logic [63:0] f_mdat_o;
    logic [1:0]  f_stall_o, f_ack_o, f_grant;
    logic        f_cyc_o, f_stb_o, f_we_o, f_err;
    logic [3:0]  f_sel_o;
    logic [14:0] f_adr_o;
    logic [31:0] f_sdat_o;
    logic [31:0] f_sdat_i = '0;
    logic        f_ack_i = 1'b0, f_stall_i = 1'b0;

    // 4-master round-robin instance
    logic [3:0]   r_cyc = '0, r_stb = '0, r_we = '0;
    logic [15:0]  r_sel = '0;
    logic [59:0]  r_adr = '0;
    logic [127:0] r_mdat = '0;
    logic [127:0] r_mdat_o;
    logic [3:0]   r_stall_o, r_ack_o, r_grant;
    logic         r_cyc_o, r_stb_o, r_we_o, r_err;
    logic [3:0]   r_sel_o;
    logic [14:0]  r_adr_o;
    logic [31:0]  r_sdat_o;
    logic [31:0]  r_sdat_i = '0;
    logic         r_ack_i = 1'b0, r_stall_i = 1'b0;

    wb_arbiter_n #(.NM(2), .AW(15), .DW(32), .MODE(0), .MAX_OUT(4)) dut_f (
        .clk_i(clk), .rst_i(rst), .cyc_i(f_cyc), .stb_i(f_stb), .we_i(f_we),
        .sel_i(f_sel), .adr_i(f_adr), .m_dat_i(f_mdat), .m_dat_o(f_mdat_o),
        .stall_o(f_stall_o), .ack_o(f_ack_o), .cyc_o(f_cyc_o), .stb_o(f_stb_o),
        .we_o(f_we_o), .sel_o(f_sel_o), .adr_o(f_adr_o), .s_dat_o(f_sdat_o),
        .s_dat_i(f_sdat_i), .ack_i(f_ack_i), .stall_i(f_stall_i),
        .grant_o(f_grant), .err_o(f_err)
    );

    wb_arbiter_n #(.NM(4), .AW(15), .DW(32), .MODE(1), .MAX_OUT(4)) dut_r (
        .clk_i(clk), .rst_i(rst), .cyc_i(r_cyc), .stb_i(r_stb), .we_i(r_we),
        .sel_i(r_sel), .adr_i(r_adr), .m_dat_i(r_mdat), .m_dat_o(r_mdat_o),
        .stall_o(r_stall_o), .ack_o(r_ack_o), .cyc_o(r_cyc_o), .stb_o(r_stb_o),
        .we_o(r_we_o), .sel_o(r_sel_o), .adr_o(r_adr_o), .s_dat_o(r_sdat_o),
        .s_dat_i(r_sdat_i), .ack_i(r_ack_i), .stall_i(r_stall_i),
        .grant_o(r_grant), .err_o(r_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] exp_rr [5];
    int         stb_seen;

    initial begin
        exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
        exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;

        // Reset held two cycles with both masters requesting
        f_cyc = 2'b11;
        step();
        step();
        check_eq("rst_grant", f_grant, 2'b00);
        check_eq("rst_cyc_o", f_cyc_o, 1'b0);
        check_eq("rst_stall", f_stall_o, 2'b11);
        check_eq("rst_err", f_err, 1'b0);
        check_eq("rst_rr_grant", r_grant, 4'b0000);

        // Fixed priority: master 0 wins one cycle after reset release
        rst = 1'b1;
        #1;
        check_eq("idle_ack", f_ack_o, 2'b00);
        step();
        check_eq("fix_grant0", f_grant, 2'b01);
        check_eq("fix_cyc_o", f_cyc_o, 1'b1);
        check_eq("fix_stall", f_stall_o, 2'b10);

        // Master 0 single read
        f_stb = 2'b01;
        f_adr = {15'h0456, 15'h0123};
        #1;
        check_eq("fix_stb_o", f_stb_o, 1'b1);
        check_eq("fix_adr_o", f_adr_o, 15'h0123);
        step();
        f_stb    = 2'b00;
        f_ack_i  = 1'b1;
        f_sdat_i = 32'h0000_cafe;
        #1;
        check_eq("fix_ack_o", f_ack_o, 2'b01);
        check_eq("fix_rdata", f_mdat_o[31:0], 32'h0000_cafe);
        step();
        f_ack_i = 1'b0;
        #1;
        check_eq("fix_hold_grant", f_grant, 2'b01);
        check_eq("fix_m1_stalled", f_stall_o[1], 1'b1);

        // Master 0 releases; master 1 takes over with no idle cycle
        f_cyc = 2'b10;
        #1;
        check_eq("rel_cyc_o", f_cyc_o, 1'b0);
        step();
        check_eq("rel_grant1", f_grant, 2'b10);
        check_eq("rel_stall", f_stall_o, 2'b00);

        // Outstanding limit: six strobes, no acks, only four forwarded
        f_stb    = 2'b10;
        stb_seen = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (f_stb_o) stb_seen++;
            if (i == 4) check_eq("full_stall", f_stall_o[1], 1'b1);
            step();
        end
        check_eq("full_stb_count", 64'(stb_seen), 64'd4);

        // Ack at full: no strobe issued, ack and data reach master 1
        f_ack_i  = 1'b1;
        f_sdat_i = 32'h1234_5678;
        #1;
        check_eq("full_ack_stb", f_stb_o, 1'b0);
        check_eq("full_ack_o", f_ack_o, 2'b10);
        check_eq("full_rdata", f_mdat_o[63:32], 32'h1234_5678);
        step();
        // out=3: strobe and ack together leave the count at 3
        #1;
        check_eq("both_stb", f_stb_o, 1'b1);
        step();
        f_ack_i = 1'b0;
        #1;
        check_eq("after_both_stb", f_stb_o, 1'b1);
        step();
        #1;
        check_eq("refull_stb", f_stb_o, 1'b0);
        check_eq("refull_stall", f_stall_o[1], 1'b1);

        // Drain two acks so two remain outstanding
        f_stb   = 2'b00;
        f_ack_i = 1'b1;
        step();
        step();
        f_ack_i = 1'b0;
        check_eq("pre_abort_err", f_err, 1'b0);

        // Abort with two outstanding; master 0 is waiting
        f_cyc = 2'b01;
        #1;
        check_eq("abort_cyc_o", f_cyc_o, 1'b0);
        step();
        check_eq("abort_grant0", f_grant, 2'b01);
        f_ack_i = 1'b1;
        #1;
        check_eq("late_ack1", f_ack_o, 2'b00);
        step();
        #1;
        check_eq("late_ack2", f_ack_o, 2'b00);
        step();
        f_ack_i = 1'b0;
        check_eq("late_err", f_err, 1'b1);
        f_cyc = 2'b00;

        // Round robin, four masters each doing one read then dropping
        r_cyc = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            check_eq("rr_grant", r_grant, exp_rr[i]);
            r_stb = exp_rr[i];
            #1;
            check_eq("rr_stb_o", r_stb_o, 1'b1);
            step();
            r_stb   = 4'b0000;
            r_ack_i = 1'b1;
            #1;
            check_eq("rr_ack_o", r_ack_o, exp_rr[i]);
            step();
            r_ack_i = 1'b0;
            r_cyc   = 4'b1111 & ~exp_rr[i];
            step();
            r_cyc = 4'b1111;
        end
        check_eq("rr_err", r_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
